ext_irq_ctrl: RTL and testbench
===============================

Name: ext_irq_ctrl

Overview:
- External interrupt aggregator placed directly upstream of the core's `ex_trap_i` input.
- Synchronises up to IRQ_N asynchronous interrupt sources and latches edge- or level-type requests into pending bits.
- Selects the highest-priority enabled request and drives a single trap request to the core, with an ack/done handshake and a stable source ID readable by the handler.

Parameters:
- IRQ_N, 8, number of interrupt sources (2..32).
- ID_W, 3, width of the source ID; must satisfy 2^ID_W >= IRQ_N.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  reset, active-low; asynchronous assert, synchronous release.
- irq_src_i  input  IRQ_N  raw asynchronous interrupt lines; bit i is source i.
- irq_en_i  input  IRQ_N  per-source enable, synchronous to clk.
- irq_edge_i  input  IRQ_N  per-source type: 1 = rising-edge, 0 = level-high; static while enabled.
- trap_ack_i  input  1  1-cycle pulse from the core on entering the trap handler.
- trap_done_i  input  1  1-cycle pulse from the core on handler return (mret).
- ex_trap_o  output  1  trap request to core `ex_trap_i`.
- trap_id_o  output  ID_W  index of the source being requested or serviced.
- irq_pend_o  output  IRQ_N  current pending vector, for debug and bench observation.

Behaviour:
- Reset: one clock, single asynchronous active-low reset `rst_n`, all flops cleared.
  - ex_trap_o=0, trap_id_o=0, irq_pend_o=0.
  - Synchroniser stages = 0; FSM = IDLE.
- Synchroniser: per source, 2-flop chain s1->s2, plus s3 holding the previous s2.
- Pending update, edge sources:
  - set when s2 & ~s3;
  - clear on trap_ack_i when trap_id_o == i;
  - set wins over clear in the same cycle.
- Pending update, level sources:
  - pend[i] = s2 every cycle;
  - not cleared by ack; the source must deassert before trap_done_i or it re-requests.
- Disabled sources keep accumulating pending bits but are never selected.
- Arbitration: cand = pend & irq_en_i; the lowest set index wins (fixed priority, bit 0 highest).
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if cand != 0 -> REQ, latch winner into trap_id_o, ex_trap_o<=1.
  - REQ: ex_trap_o held at 1 and trap_id_o frozen until trap_ack_i. On ack -> SERVICE, ex_trap_o<=0, clear pend[id] if that source is edge type. Enable deassertion or higher-priority arrivals do not withdraw or change the request.
  - SERVICE: ex_trap_o=0, trap_id_o held (no nesting). On trap_done_i -> IDLE. Arbitration resumes the cycle after, so back-to-back traps have at least 1 idle cycle with ex_trap_o=0.
- Latency: a source rising before clock edge E0 sets pend at E2 (edge type: s2&~s3 registered) and ex_trap_o=1 after E3. That is 4 edges from sample to request, counting the sampling edge E0.
- Spurious handshakes:
  - trap_ack_i outside REQ is ignored.
  - trap_done_i outside SERVICE is ignored.
  - ack and done asserted in the same cycle in REQ: ack taken, done ignored.
- Reset mid-operation: everything returns to reset values. Edges occurring during reset are lost; levels still high are seen 2 cycles after release.
- An edge source toggling faster than service merges into one pending bit; no counting.

Test Plan:
- Single edge source 2, enabled: pulse irq_src_i[2] for 3 cycles -> ex_trap_o=1 on the 4th edge after sampling, trap_id_o=2; ack -> ex_trap_o=0, irq_pend_o[2]=0; done -> FSM IDLE, no re-request.
- Priority: sources 5 and 1 raised in the same cycle, both edge -> trap_id_o=1 first. After ack+done, the next request has trap_id_o=5 with 1 idle cycle between requests.
- Level source 3 held high through done -> second request with trap_id_o=3 immediately after IDLE. Deassert before done -> no second request.
- Masking: edge on source 4 with irq_en_i[4]=0 -> irq_pend_o[4]=1, ex_trap_o stays 0. Later set irq_en_i[4]=1 -> request with trap_id_o=4.
- Handshake corner cases:
  - new edge on the serviced source in the same cycle as ack -> pend stays 1, re-request after done;
  - trap_done_i pulsed in IDLE -> no effect.
- Reset mid-REQ: assert rst_n=0 while ex_trap_o=1 -> ex_trap_o, trap_id_o and irq_pend_o are 0 immediately (asynchronous), with no request after release unless a source is level-high.

Source files
------------

// File: rtl/ext_irq_ctrl.sv
// External interrupt aggregator: synchronises raw IRQ lines, latches edge/level requests
// into pending bits and presents one fixed-priority trap request to the core.
module ext_irq_ctrl #(
   parameter int IRQ_N = 8,
   parameter int ID_W  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IRQ_N-1:0] irq_src_i,
   input  logic [IRQ_N-1:0] irq_en_i,
   input  logic [IRQ_N-1:0] irq_edge_i,
   input  logic             trap_ack_i,
   input  logic             trap_done_i,
   output logic             ex_trap_o,
   output logic [ID_W-1:0]  trap_id_o,
   output logic [IRQ_N-1:0] irq_pend_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [IRQ_N-1:0] s1_q, s2_q, s3_q;
   logic [IRQ_N-1:0] pend_q, pend_d;
   logic [IRQ_N-1:0] cand;
   logic             ex_trap_q, ex_trap_d;
   logic [ID_W-1:0]  trap_id_q, trap_id_d;
   logic [ID_W-1:0]  winner;
   logic             any_cand;
   logic             ack_take;

   // An ack only counts while a request is outstanding.
   assign ack_take = (state_q == ST_REQ) && trap_ack_i;
   assign cand     = pend_q & irq_en_i;
   assign any_cand = |cand;

   always_comb begin
      winner = '0;
      for (int i = IRQ_N - 1; i >= 0; i--) begin
         if (cand[i]) winner = ID_W'(i);
      end
   end

   // Edge sources: a fresh rising edge beats the ack clear in the same cycle.
   always_comb begin
      pend_d = '0;
      for (int i = 0; i < IRQ_N; i++) begin
         if (irq_edge_i[i]) begin
            pend_d[i] = (pend_q[i] & ~(ack_take && (trap_id_q == ID_W'(i))))
                      | (s2_q[i] & ~s3_q[i]);
         end else begin
            pend_d[i] = s2_q[i];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ex_trap_d = ex_trap_q;
      trap_id_d = trap_id_q;
      case (state_q)
         ST_IDLE: begin
            if (any_cand) begin
               state_d   = ST_REQ;
               ex_trap_d = 1'b1;
               trap_id_d = winner;
            end
         end
         ST_REQ: begin
            if (trap_ack_i) begin
               state_d   = ST_SERVICE;
               ex_trap_d = 1'b0;
            end
         end
         ST_SERVICE: begin
            if (trap_done_i) state_d = ST_IDLE;
         end
         default: begin
            state_d   = ST_IDLE;
            ex_trap_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q      <= '0;
         s2_q      <= '0;
         s3_q      <= '0;
         pend_q    <= '0;
         state_q   <= ST_IDLE;
         ex_trap_q <= 1'b0;
         trap_id_q <= '0;
      end else begin
         s1_q      <= irq_src_i;
         s2_q      <= s1_q;
         s3_q      <= s2_q;
         pend_q    <= pend_d;
         state_q   <= state_d;
         ex_trap_q <= ex_trap_d;
         trap_id_q <= trap_id_d;
      end
   end

   assign ex_trap_o  = ex_trap_q;
   assign trap_id_o  = trap_id_q;
   assign irq_pend_o = pend_q;

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Bench for ext_irq_ctrl: a directed vector table, hand sequences for handshake/reset
// corners, and a randomized run against a queue-based reference model.
module tb_ext_irq_ctrl;

   localparam int IRQ_N = 8;
   localparam int ID_W  = 3;
   localparam int M_IDLE = 0, M_REQ = 1, M_SVC = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [IRQ_N-1:0] irq_src_i, irq_en_i, irq_edge_i;
   logic             trap_ack_i, trap_done_i;
   logic             ex_trap_o;
   logic [ID_W-1:0]  trap_id_o;
   logic [IRQ_N-1:0] irq_pend_o;

   ext_irq_ctrl #(.IRQ_N(IRQ_N), .ID_W(ID_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .irq_src_i   (irq_src_i),
      .irq_en_i    (irq_en_i),
      .irq_edge_i  (irq_edge_i),
      .trap_ack_i  (trap_ack_i),
      .trap_done_i (trap_done_i),
      .ex_trap_o   (ex_trap_o),
      .trap_id_o   (trap_id_o),
      .irq_pend_o  (irq_pend_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: history of sampled lines, pending set, handshake phase.
   logic [IRQ_N-1:0] seen_q[$];
   logic [IRQ_N-1:0] m_pend;
   int               m_mode;
   int               m_id;
   logic             m_trap;

   typedef struct {
      logic [IRQ_N-1:0] src;
      logic             ack;
      logic             done;
      logic             exp_trap;
      logic [ID_W-1:0]  exp_id;
      logic [IRQ_N-1:0] exp_pend;
   } vec_t;
   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int first_set(input logic [IRQ_N-1:0] v);
      for (int i = 0; i < IRQ_N; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      seen_q.delete();
      repeat (3) seen_q.push_back('0);
      m_pend = '0;
      m_mode = M_IDLE;
      m_id   = 0;
      m_trap = 1'b0;
   endtask

   task automatic model_edge();
      logic [IRQ_N-1:0] now_v, prev_v, rise, nxt;
      int w;
      // Line value two samples back is what the core domain sees now.
      now_v  = seen_q[1];
      prev_v = seen_q[2];
      rise   = now_v & ~prev_v;
      for (int i = 0; i < IRQ_N; i++)
         nxt[i] = irq_edge_i[i] ? (m_pend[i] | rise[i]) : now_v[i];
      if (m_mode == M_REQ && trap_ack_i && irq_edge_i[m_id] && !rise[m_id])
         nxt[m_id] = 1'b0;
      case (m_mode)
         M_IDLE: begin
            w = first_set(m_pend & irq_en_i);
            if (w >= 0) begin
               m_mode = M_REQ;
               m_id   = w;
               m_trap = 1'b1;
            end
         end
         M_REQ: if (trap_ack_i) begin
            m_mode = M_SVC;
            m_trap = 1'b0;
         end
         default: if (trap_done_i) m_mode = M_IDLE;
      endcase
      m_pend = nxt;
      seen_q.push_front(irq_src_i);
      void'(seen_q.pop_back());
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_edge();
      #1;
      chk("ex_trap", ex_trap_o, m_trap);
      chk("trap_id", trap_id_o, m_id);
      chk("irq_pend", irq_pend_o, m_pend);
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic pulse_ack();
      trap_ack_i = 1'b1;
      step();
      trap_ack_i = 1'b0;
   endtask

   task automatic pulse_done();
      trap_done_i = 1'b1;
      step();
      trap_done_i = 1'b0;
   endtask

   task automatic wait_trap(input string name, input int budget);
      int c = 0;
      while (!ex_trap_o && c < budget) begin
         step();
         c++;
      end
      if (!ex_trap_o) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: no request within %0d cycles, ex_trap_o=%0b expected 1", name, budget, ex_trap_o);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      // Single edge pulse on source 2, then ack and done.
      vecs[0] = '{8'h04, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00};
      vecs[1] = '{8'h04, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00};
      vecs[2] = '{8'h04, 1'b0, 1'b0, 1'b0, 3'd0, 8'h04};
      vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04};
      vecs[4] = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04};
      vecs[5] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd2, 8'h00};
      vecs[6] = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd2, 8'h00};
      vecs[7] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00};
      vecs[8] = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd2, 8'h00};
      vecs[9] = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd2, 8'h00};

      rst_n       = 1'b0;
      irq_src_i   = '0;
      irq_en_i    = '1;
      irq_edge_i  = '1;
      trap_ack_i  = 1'b0;
      trap_done_i = 1'b0;
      model_reset();
      #1;
      chk("reset_ex_trap", ex_trap_o, 0);
      chk("reset_trap_id", trap_id_o, 0);
      chk("reset_pend", irq_pend_o, 0);
      idle(2);
      rst_n = 1'b1;
      idle(3);

      for (int k = 0; k < 10; k++) begin
         irq_src_i   = vecs[k].src;
         trap_ack_i  = vecs[k].ack;
         trap_done_i = vecs[k].done;
         step();
         chk($sformatf("vec%0d_trap", k), ex_trap_o, vecs[k].exp_trap);
         chk($sformatf("vec%0d_id", k), trap_id_o, vecs[k].exp_id);
         chk($sformatf("vec%0d_pend", k), irq_pend_o, vecs[k].exp_pend);
      end
      trap_ack_i  = 1'b0;
      trap_done_i = 1'b0;

      // Priority: 5 and 1 together, 1 wins, then 5 after an idle cycle.
      irq_src_i = 8'h22;
      idle(2);
      irq_src_i = 8'h00;
      wait_trap("prio_first", 20);
      chk("prio_first_id", trap_id_o, 1);
      pulse_ack();
      idle(1);
      pulse_done();
      chk("prio_idle_gap", ex_trap_o, 0);
      wait_trap("prio_second", 5);
      chk("prio_second_id", trap_id_o, 5);
      pulse_ack();
      pulse_done();
      idle(3);

      // Level source 3: held through done re-requests, released before done does not.
      irq_edge_i[3] = 1'b0;
      irq_src_i[3]  = 1'b1;
      wait_trap("level_first", 20);
      chk("level_first_id", trap_id_o, 3);
      pulse_ack();
      chk("level_pend_kept", irq_pend_o[3], 1);
      idle(1);
      pulse_done();
      chk("level_gap", ex_trap_o, 0);
      step();
      chk("level_rereq", ex_trap_o, 1);
      chk("level_rereq_id", trap_id_o, 3);
      pulse_ack();
      irq_src_i[3] = 1'b0;
      idle(4);
      pulse_done();
      idle(6);
      chk("level_no_rereq", ex_trap_o, 0);
      irq_edge_i[3] = 1'b1;

      // Masking: disabled source 4 still pends but never requests.
      irq_en_i[4]  = 1'b0;
      irq_src_i[4] = 1'b1;
      idle(2);
      irq_src_i[4] = 1'b0;
      idle(4);
      chk("mask_pend", irq_pend_o[4], 1);
      chk("mask_no_req", ex_trap_o, 0);
      irq_en_i[4] = 1'b1;
      wait_trap("mask_enable", 5);
      chk("mask_id", trap_id_o, 4);
      pulse_ack();
      pulse_done();
      idle(2);

      // New edge on the serviced source lands in the ack cycle.
      irq_src_i[6] = 1'b1;
      idle(2);
      irq_src_i[6] = 1'b0;
      wait_trap("collide_first", 20);
      chk("collide_first_id", trap_id_o, 6);
      irq_src_i[6] = 1'b1;
      idle(2);
      pulse_ack();
      chk("collide_pend", irq_pend_o[6], 1);
      chk("collide_ack_drop", ex_trap_o, 0);
      irq_src_i[6] = 1'b0;
      idle(2);
      pulse_done();
      wait_trap("collide_rereq", 5);
      chk("collide_rereq_id", trap_id_o, 6);
      pulse_ack();
      pulse_done();
      idle(2);

      // Spurious handshakes in IDLE, then ack+done together in REQ.
      pulse_done();
      pulse_ack();
      idle(2);
      chk("spurious_idle", ex_trap_o, 0);
      irq_src_i = 8'h05;
      idle(2);
      irq_src_i = 8'h00;
      wait_trap("ackdone_first", 20);
      chk("ackdone_first_id", trap_id_o, 0);
      trap_ack_i  = 1'b1;
      trap_done_i = 1'b1;
      step();
      trap_ack_i  = 1'b0;
      trap_done_i = 1'b0;
      idle(3);
      chk("ackdone_done_ignored", ex_trap_o, 0);
      pulse_done();
      wait_trap("ackdone_next", 5);
      chk("ackdone_next_id", trap_id_o, 2);
      pulse_ack();
      pulse_done();
      idle(2);

      // Reset while a request is outstanding.
      irq_src_i[1] = 1'b1;
      idle(2);
      irq_src_i[1] = 1'b0;
      wait_trap("rst_first", 20);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_trap", ex_trap_o, 0);
      chk("rst_async_id", trap_id_o, 0);
      chk("rst_async_pend", irq_pend_o, 0);
      model_reset();
      step();
      rst_n = 1'b1;
      idle(8);
      chk("rst_no_req", ex_trap_o, 0);

      // Level source 7 high across reset requests again after release.
      irq_edge_i[7] = 1'b0;
      irq_src_i[7]  = 1'b1;
      wait_trap("rst_lvl_pre", 20);
      #2;
      rst_n = 1'b0;
      model_reset();
      step();
      rst_n = 1'b1;
      wait_trap("rst_lvl_post", 10);
      chk("rst_lvl_id", trap_id_o, 7);
      pulse_ack();
      irq_src_i[7] = 1'b0;
      idle(4);
      pulse_done();
      idle(3);

      // Randomized traffic against the model.
      irq_edge_i = IRQ_N'($urandom);
      irq_en_i   = IRQ_N'($urandom);
      for (int n = 0; n < 2000; n++) begin
         irq_src_i = irq_src_i ^ (IRQ_N'($urandom) & IRQ_N'($urandom) & IRQ_N'($urandom));
         if ($urandom_range(0, 49) == 0) irq_en_i = IRQ_N'($urandom);
         trap_ack_i  = (m_mode == M_REQ) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
         trap_done_i = (m_mode == M_SVC) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
         step();
      end
      trap_ack_i  = 1'b0;
      trap_done_i = 1'b0;
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
